// File: rtl/e_muldiv_unit.sv
// Execute-stage multiply/divide unit that owns the architectural HI/LO registers.
// Results are computed at the start edge, held pending, and committed after a fixed busy latency.
module e_muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;

  // Returns {hi, lo}; unsigned operands are zero-extended so one signed multiply covers both.
  function automatic logic [63:0] mul_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (is_signed) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end
    return sa * sb;
  endfunction

  // Returns {remainder, quotient}; a zero divisor leaves the current HI/LO in place.
  function automatic logic [63:0] div_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed,
                                          input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q;
    logic signed [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'h0)
      return {cur_hi, cur_lo};
    else if (!is_signed)
      return {a % b, a / b};
    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {32'h0, 32'h8000_0000};
    else begin
      q = sa / sb;
      r = sa % sb;
      return {r, q};
    end
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (md_op)
              3'd1, 3'd2: begin
                {pend_hi, pend_lo} <= mul_res(src_a, src_b, md_op == 3'd1);
                count              <= CNT_W'(MULT_CYCLES);
                state              <= BUSY;
              end
              3'd3, 3'd4: begin
                {pend_hi, pend_lo} <= div_res(src_a, src_b, md_op == 3'd3, hi, lo);
                count              <= CNT_W'(DIV_CYCLES);
                state              <= BUSY;
              end
              3'd5:    hi <= src_a;
              3'd6:    lo <= src_a;
              default: ;
            endcase
          end
        end
        BUSY: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == BUSY);

  // Upstream hazard logic is expected to stall any real op while the unit is busy.
  always_ff @(posedge clk) begin
    if (reset && busy && start)
      assert (md_op == 3'd0 || md_op == 3'd7)
        else $warning("e_muldiv_unit: md_op %0d issued while busy was ignored", md_op);
  end

endmodule
